parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
- Multi-channel, framed successor to the single-bit serial Moore parity checker.
- Each of NUM_CH independent serial lanes accumulates parity over FRAME_LEN data bits, then checks a received parity bit against the selected even/odd mode.
- Reports per-frame completion and error, and keeps a saturating per-channel error count.
- Sits behind serial receive lanes, ahead of link-status/CSR logic.

Parameters:
- NUM_CH, 4, number of independent serial channels.
- FRAME_LEN, 8, data bits per frame (excluding the parity bit); legal range 1..255.
- ERR_CNT_W, 8, width of each per-channel saturating error counter.

Ports:
- clk, input, 1, clock; all logic on posedge.
- rstn, input, 1, reset, synchronous, active-low.
- odd_mode, input, 1, global mode: 0 = even parity expected, 1 = odd; sampled only in the cycle a parity bit is accepted.
- in_valid, input, NUM_CH, per-channel bit strobe.
- in_bit, input, NUM_CH, per-channel serial data; qualified by in_valid.
- abort, input, NUM_CH, per-channel frame restart (resync).
- err_clr, input, NUM_CH, per-channel error-counter clear.
- parity, output, NUM_CH, registered running parity of data bits accepted so far in the current frame (Moore output of state).
- frame_done, output, NUM_CH, one-cycle pulse: frame completed.
- frame_err, output, NUM_CH, parity mismatch for the completed frame; valid only while frame_done=1, else 0.
- err_cnt, output, NUM_CH*ERR_CNT_W, packed per-channel error counts; channel c occupies bits [c*ERR_CNT_W +: ERR_CNT_W].

Behaviour:
- Per-channel state:
  - par_state ∈ {EVEN, ODD}; reset EVEN.
  - bit_cnt, 0..FRAME_LEN; reset 0.
  - err_cnt; reset 0.
- Reset (rstn=0 at posedge): parity=0, frame_done=0, frame_err=0, err_cnt=0, bit_cnt=0, par_state=EVEN, for every channel.
- Data phase (in_valid=1, abort=0, bit_cnt<FRAME_LEN):
  - par_state toggles iff in_bit=1.
  - bit_cnt increments.
  - parity output reflects the new state the next cycle.
- Parity phase (in_valid=1, abort=0, bit_cnt==FRAME_LEN): the bit is the received parity bit.
  - err = (par_state XOR in_bit) != odd_mode.
  - Next cycle: frame_done=1, frame_err=err.
  - par_state returns to EVEN and bit_cnt to 0 (back-to-back frames have no gap cycle).
- Latency: frame_done/frame_err are registered, asserting in the cycle after the parity bit is accepted.
- in_valid=0: state holds, no pulse.
- abort=1: par_state=EVEN, bit_cnt=0, no frame_done. Abort overrides a simultaneous in_valid, including a parity-phase bit, which is discarded. Abort does not touch err_cnt.
- err_cnt update:
  - +1 on each err=1 frame.
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - err_clr=1 forces 0 next cycle and wins over a simultaneous increment.
- odd_mode may change mid-frame; only its value at the parity-bit cycle matters.
- Channels are fully independent; activity on one never affects another.
- A reset asserted mid-frame discards the partial frame without a pulse.

Decomposition:
- Package parity_pkg:
  - typedef enum logic {EVEN=1'b0, ODD=1'b1} par_state_t.
  - typedef enum logic {MODE_EVEN=1'b0, MODE_ODD=1'b1} par_mode_t.
- Sub-module parity_channel: one lane holding the FSM, bit counter, check logic and saturating counter, parametrised by FRAME_LEN and ERR_CNT_W.
- Top level: generate loop of NUM_CH parity_channel instances, plus err_cnt packing.

Test Plan (NUM_CH=4, FRAME_LEN=8, ERR_CNT_W=8):
- Reset: rstn=0 for 2 cycles with in_valid toggling -> all outputs 0. First frame after release behaves normally.
- Even mode, ch0 data 8'b1011_0010 (4 ones), parity bit 0 -> frame_done[0] pulses 1 cycle after parity bit, frame_err[0]=0, err_cnt[0]=0. Parity bit 1 on the next frame -> frame_err[0]=1, err_cnt[0]=1.
- Odd mode, ch2 data 8'b0000_0111 (3 ones), parity bit 0 -> frame_err[2]=0. Then two back-to-back frames with no gap, both bad -> two pulses 9 cycles apart, err_cnt[2]=2.
- Abort: ch1 after 5 data bits, then a full good 8+1 frame -> exactly one frame_done[1], frame_err=0. Abort coincident with the parity bit -> no pulse, bit_cnt=0.
- Saturation/clear: 260 bad frames on ch3 -> err_cnt[3] stays 255. err_clr[3] coincident with another bad frame -> err_cnt[3]=0.
- Independence: random simultaneous traffic on all 4 channels with gaps in in_valid -> per-channel results match a reference model. parity output equals the XOR of accepted data bits every cycle.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types for the framed multi-channel parity checker.
package parity_pkg;

   typedef enum logic {EVEN = 1'b0, ODD = 1'b1} par_state_t;
   typedef enum logic {MODE_EVEN = 1'b0, MODE_ODD = 1'b1} par_mode_t;

endpackage

// File: rtl/parity_frame_checker_channel.sv
// One serial lane: Moore parity FSM, frame bit counter, parity check and
// saturating error counter.
module parity_channel
   import parity_pkg::*;
#(
   parameter int FRAME_LEN = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 odd_mode_i,
   input  logic                 in_valid_i,
   input  logic                 in_bit_i,
   input  logic                 abort_i,
   input  logic                 err_clr_i,
   output logic                 parity_o,
   output logic                 frame_done_o,
   output logic                 frame_err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int                   CNT_W   = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0]     LAST    = CNT_W'(FRAME_LEN);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   par_state_t           state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   par_mode_t            mode;
   logic                 mismatch;

   assign mode     = par_mode_t'(odd_mode_i);
   // Data parity plus received bit must equal the selected mode.
   assign mismatch = (((state_q == ODD) ^ in_bit_i) != (mode == MODE_ODD));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= EVEN;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (abort_i) begin
         state_d   = EVEN;
         bit_cnt_d = '0;
      end else if (in_valid_i) begin
         if (bit_cnt_q == LAST) begin
            done_d    = 1'b1;
            err_d     = mismatch;
            state_d   = EVEN;
            bit_cnt_d = '0;
            if (mismatch && (err_cnt_q != CNT_MAX))
               err_cnt_d = err_cnt_q + 1'b1;
         end else begin
            if (in_bit_i)
               state_d = (state_q == ODD) ? EVEN : ODD;
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end
      // Clear beats a same-cycle increment.
      if (err_clr_i)
         err_cnt_d = '0;
   end

   assign parity_o     = (state_q == ODD);
   assign frame_done_o = done_q;
   assign frame_err_o  = err_q;
   assign err_cnt_o    = err_cnt_q;

endmodule

// File: rtl/parity_frame_checker.sv
// NUM_CH independent framed parity lanes with packed per-channel error counts.
module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int FRAME_LEN = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          odd_mode,
   input  logic [NUM_CH-1:0]             in_valid,
   input  logic [NUM_CH-1:0]             in_bit,
   input  logic [NUM_CH-1:0]             abort,
   input  logic [NUM_CH-1:0]             err_clr,
   output logic [NUM_CH-1:0]             parity,
   output logic [NUM_CH-1:0]             frame_done,
   output logic [NUM_CH-1:0]             frame_err,
   output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      parity_channel #(
         .FRAME_LEN (FRAME_LEN),
         .ERR_CNT_W (ERR_CNT_W)
      ) u_ch (
         .clk          (clk),
         .rstn         (rstn),
         .odd_mode_i   (odd_mode),
         .in_valid_i   (in_valid[g]),
         .in_bit_i     (in_bit[g]),
         .abort_i      (abort[g]),
         .err_clr_i    (err_clr[g]),
         .parity_o     (parity[g]),
         .frame_done_o (frame_done[g]),
         .frame_err_o  (frame_err[g]),
         .err_cnt_o    (err_cnt[g*ERR_CNT_W +: ERR_CNT_W])
      );
   end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: a behavioural lane model pushes expected frame results,
// a negedge monitor pops them when frame_done pulses.
module tb_parity_frame_checker;

   localparam int NCH = 4;
   localparam int FL  = 8;
   localparam int EW  = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic             odd_mode;
   logic [NCH-1:0]   in_valid, in_bit, abort, err_clr;
   logic [NCH-1:0]   parity, frame_done, frame_err;
   logic [NCH*EW-1:0] err_cnt;

   parity_frame_checker #(.NUM_CH(NCH), .FRAME_LEN(FL), .ERR_CNT_W(EW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .odd_mode   (odd_mode),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .abort      (abort),
      .err_clr    (err_clr),
      .parity     (parity),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb [NCH][$];
   int   n_pass = 0, n_tot = 0;
   bit   mon_en = 0;
   int   cyc = 0;
   logic m_par [NCH];
   int   m_cnt [NCH];
   int   m_err [NCH];
   int   pulses [NCH];
   int   last_cyc [NCH];
   int   prev_cyc [NCH];
   logic last_err [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_par[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
         pulses[c] = 0; last_cyc[c] = 0; prev_cyc[c] = 0; last_err[c] = 0;
      end
   end

   // Monitor: running parity and counters every cycle, frame results via scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         for (int c = 0; c < NCH; c++) begin
            n_tot++;
            if (parity[c] !== m_par[c])
               $display("FAIL parity ch%0d cyc%0d: got %b exp %b", c, cyc, parity[c], m_par[c]);
            else n_pass++;
            n_tot++;
            if (err_cnt[c*EW +: EW] !== 8'(m_err[c]))
               $display("FAIL err_cnt ch%0d cyc%0d: got %0d exp %0d", c, cyc, err_cnt[c*EW +: EW], m_err[c]);
            else n_pass++;
            if (sb[c].size() > 0) begin
               exp_t e;
               e = sb[c].pop_front();
               n_tot++;
               if (frame_done[c] !== 1'b1)
                  $display("FAIL missing_done ch%0d cyc%0d: got %b exp 1", c, cyc, frame_done[c]);
               else n_pass++;
               n_tot++;
               if (frame_err[c] !== e.err || err_cnt[c*EW +: EW] !== e.cnt)
                  $display("FAIL frame_result ch%0d cyc%0d: got err=%b cnt=%0d exp err=%b cnt=%0d",
                           c, cyc, frame_err[c], err_cnt[c*EW +: EW], e.err, e.cnt);
               else n_pass++;
            end else begin
               n_tot++;
               if (frame_done[c] !== 1'b0 || frame_err[c] !== 1'b0)
                  $display("FAIL spurious_done ch%0d cyc%0d: got done=%b err=%b exp 0/0",
                           c, cyc, frame_done[c], frame_err[c]);
               else n_pass++;
            end
            if (frame_done[c] === 1'b1) begin
               pulses[c]++;
               prev_cyc[c] = last_cyc[c];
               last_cyc[c] = cyc;
               last_err[c] = frame_err[c];
            end
         end
      end
   end

   // Drive one cycle and advance the reference model at the sampling edge.
   task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                        input logic [NCH-1:0] ab, input logic [NCH-1:0] clr,
                        input logic mode);
      in_valid = v; in_bit = b; abort = ab; err_clr = clr; odd_mode = mode;
      @(posedge clk);
      for (int c = 0; c < NCH; c++) begin
         logic e, fin;
         e = 1'b0; fin = 1'b0;
         if (!rstn) begin
            m_par[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
         end else begin
            if (ab[c]) begin
               m_par[c] = 0; m_cnt[c] = 0;
            end else if (v[c]) begin
               if (m_cnt[c] == FL) begin
                  e   = ((m_par[c] ^ b[c]) != mode);
                  fin = 1'b1;
                  m_par[c] = 0; m_cnt[c] = 0;
               end else begin
                  m_par[c] = m_par[c] ^ b[c];
                  m_cnt[c]++;
               end
            end
            if (clr[c]) m_err[c] = 0;
            else if (e && m_err[c] < 255) m_err[c]++;
            if (fin) sb[c].push_back('{e, 8'(m_err[c])});
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, 1'b0);
   endtask

   task automatic send_data(input int ch, input logic [7:0] d, input logic mode);
      logic [NCH-1:0] v, b;
      for (int i = FL - 1; i >= 0; i--) begin
         v = '0; b = '0; v[ch] = 1'b1; b[ch] = d[i];
         cycle(v, b, '0, '0, mode);
      end
   endtask

   task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit, input logic mode);
      logic [NCH-1:0] v, b;
      send_data(ch, d, mode);
      v = '0; b = '0; v[ch] = 1'b1; b[ch] = pbit;
      cycle(v, b, '0, '0, mode);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      cycle('1, '1, '0, '0, 1'b0);
      mon_en = 1;
      cycle('0, '1, '0, '0, 1'b1);
      n_tot++;
      if (parity !== '0 || frame_done !== '0 || frame_err !== '0 || err_cnt !== '0)
         $display("FAIL reset_outputs: got par=%b done=%b err=%b cnt=%h exp all 0",
                  parity, frame_done, frame_err, err_cnt);
      else n_pass++;
      rstn = 1'b1;
      idle(1);
   endtask

   task automatic test_even();
      int p0;
      p0 = pulses[0];
      send_frame(0, 8'b1011_0010, 1'b0, 1'b0);
      idle(1);
      n_tot++;
      if (pulses[0] - p0 != 1 || last_err[0] !== 1'b0 || err_cnt[7:0] !== 8'd0)
         $display("FAIL even_good: got pulses=%0d err=%b cnt=%0d exp 1/0/0",
                  pulses[0] - p0, last_err[0], err_cnt[7:0]);
      else n_pass++;
      send_frame(0, 8'b1011_0010, 1'b1, 1'b0);
      idle(1);
      n_tot++;
      if (last_err[0] !== 1'b1 || err_cnt[7:0] !== 8'd1)
         $display("FAIL even_bad: got err=%b cnt=%0d exp 1/1", last_err[0], err_cnt[7:0]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      send_frame(2, 8'b0000_0111, 1'b0, 1'b1);
      idle(1);
      n_tot++;
      if (last_err[2] !== 1'b0)
         $display("FAIL odd_good: got err=%b exp 0", last_err[2]);
      else n_pass++;
      send_frame(2, 8'b0000_0111, 1'b1, 1'b1);
      send_frame(2, 8'b0000_0111, 1'b1, 1'b1);
      idle(1);
      n_tot++;
      if (last_cyc[2] - prev_cyc[2] != 9 || last_err[2] !== 1'b1 || err_cnt[23:16] !== 8'd2)
         $display("FAIL back_to_back: got gap=%0d err=%b cnt=%0d exp 9/1/2",
                  last_cyc[2] - prev_cyc[2], last_err[2], err_cnt[23:16]);
      else n_pass++;
   endtask

   task automatic test_abort();
      int p0;
      p0 = pulses[1];
      for (int i = 0; i < 5; i++) cycle(4'b0010, 4'b0010, '0, '0, 1'b0);
      cycle('0, '0, 4'b0010, '0, 1'b0);
      send_frame(1, 8'b1100_0000, 1'b0, 1'b0);
      idle(1);
      n_tot++;
      if (pulses[1] - p0 != 1 || last_err[1] !== 1'b0)
         $display("FAIL abort_mid: got pulses=%0d err=%b exp 1/0", pulses[1] - p0, last_err[1]);
      else n_pass++;
      p0 = pulses[1];
      send_data(1, 8'b1010_1010, 1'b0);
      cycle(4'b0010, 4'b0010, 4'b0010, '0, 1'b0);
      idle(2);
      n_tot++;
      if (pulses[1] != p0)
         $display("FAIL abort_parity: got pulses=%0d exp 0", pulses[1] - p0);
      else n_pass++;
      send_frame(1, 8'b1110_0000, 1'b1, 1'b0);
      idle(1);
      n_tot++;
      if (pulses[1] - p0 != 1 || last_err[1] !== 1'b0)
         $display("FAIL abort_recover: got pulses=%0d err=%b exp 1/0", pulses[1] - p0, last_err[1]);
      else n_pass++;
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) send_frame(3, 8'h00, 1'b1, 1'b0);
      idle(1);
      n_tot++;
      if (err_cnt[31:24] !== 8'd255)
         $display("FAIL saturate: got %0d exp 255", err_cnt[31:24]);
      else n_pass++;
      send_data(3, 8'h00, 1'b0);
      cycle(4'b1000, 4'b1000, '0, 4'b1000, 1'b0);
      idle(1);
      n_tot++;
      if (err_cnt[31:24] !== 8'd0 || last_err[3] !== 1'b1)
         $display("FAIL clear_wins: got cnt=%0d err=%b exp 0/1", err_cnt[31:24], last_err[3]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [NCH-1:0] v, b, ab, clr;
      for (int i = 0; i < 600; i++) begin
         v = '0; b = '0; ab = '0; clr = '0;
         for (int c = 0; c < NCH; c++) begin
            v[c]   = ($urandom_range(0, 3) != 0);
            b[c]   = 1'($urandom_range(0, 1));
            ab[c]  = ($urandom_range(0, 40) == 0);
            clr[c] = ($urandom_range(0, 60) == 0);
         end
         cycle(v, b, ab, clr, 1'($urandom_range(0, 1)));
      end
      idle(2);
   endtask

   initial begin
      rstn = 1'b0; odd_mode = 1'b0;
      in_valid = '0; in_bit = '0; abort = '0; err_clr = '0;
      test_reset();
      test_even();
      test_back_to_back();
      test_abort();
      test_saturation();
      test_random();
      for (int c = 0; c < NCH; c++) begin
         n_tot++;
         if (sb[c].size() != 0)
            $display("FAIL scoreboard_drain ch%0d: got %0d left exp 0", c, sb[c].size());
         else n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
